regfile_mc: RTL and testbench

Parametrised two-read, one-write register file for the multicycle datapath, replacing the single-entry register slice. Read data is captured into internal A/B output registers under an explicit load enable, matching the multicycle register-read step. Storage is cleared by a sequential init engine after reset rather than by per-flop reset, so the array can map to distributed RAM. Optional write-to-read forwarding is selected at compile time.

---
 rtl/regfile_mc.sv | 79 +++++++
 tb/tb_regfile_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mc.sv
// regfile_mc: 2R1W register file with registered A/B read ports and a sequential clear engine after reset.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_mc #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, next_state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_wa;
    logic [DATA_W-1:0]  mem_wd;
    logic               rd_zero, fwd_a, fwd_b;
    logic [DATA_W-1:0]  val_a, val_b;

    assign rd_zero = (ZERO_REG != 0) && (rd == '0);

`ifdef REGFILE_BYPASS_EN
    assign fwd_a = wr_en && !rd_zero && (rs == rd);
    assign fwd_b = wr_en && !rd_zero && (rt == rd);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        val_a = fwd_a ? wr_data : ((ZERO_REG != 0) && (rs == '0)) ? '0 : mem[rs];
        val_b = fwd_b ? wr_data : ((ZERO_REG != 0) && (rt == '0)) ? '0 : mem[rt];
    end

    // The clear engine owns the write port while in INIT; user writes only land in RUN.
    always_comb begin
        next_state = rst ? INIT : (state == INIT && clr_cnt == ADDR_W'(DEPTH - 1)) ? RUN : state;
        mem_we     = !rst && ((state == INIT) || (wr_en && !rd_zero));
        mem_wa     = (state == INIT) ? clr_cnt : rd;
        mem_wd     = (state == INIT) ? '0 : wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            ready   <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
        end else begin
            state <= next_state;
            ready <= (next_state == RUN);
            if (state == INIT)
                clr_cnt <= clr_cnt + 1'b1;
            else if (rd_en) begin
                out_a <= val_a;
                out_b <= val_b;
            end
        end
    end
endmodule

// File: tb/tb_regfile_mc.sv
// tb_regfile_mc: directed self-checking bench for regfile_mc (default build plus a ZERO_REG=0 instance).
module tb_regfile_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        ready, ready0;
    logic [31:0] out_a, out_b, out_a0, out_b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_mc #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .rs(rs), .rt(rt), .rd(rd),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .out_a(out_a), .out_b(out_b)
    );

    regfile_mc #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0), .rs(rs), .rt(rt), .rd(rd),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .out_a(out_a0), .out_b(out_b0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        rd = idx; wr_data = val; wr_en = 1'b1; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_regs(input logic [4:0] a, input logic [4:0] b);
        rs = a; rt = b; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Waits for ready after a reset edge, checking outputs stay 0 and the edge count is DEPTH.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            checks++;
            if (out_a !== 32'h0 || out_b !== 32'h0) begin
                errors++;
                $display("FAIL %s_outs_during_init: out_a=%h out_b=%h required 0", name, out_a, out_b);
            end
        end
        checks++;
        if (n != 32 || !ready) begin
            errors++;
            $display("FAIL %s_ready_edges: ready=%b after %0d edges, required 1 after 32", name, ready, n);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b out_a=%h out_b=%h required 0/0/0", ready, out_a, out_b);
        end
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL init_ready_low edge %0d: ready=%b required 0", i, ready);
            end
        end
        tick();
        checks++;
        if (ready !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL init_ready_edge32: ready=%b ready0=%b required 1", ready, ready0);
        end
        for (int i = 0; i < 32; i++) begin
            read_regs(5'(i), 5'(31 - i));
            checks++;
            if (out_a !== 32'h0 || out_b !== 32'h0 || out_a0 !== 32'h0) begin
                errors++;
                $display("FAIL init_clear r%0d: out_a=%h out_b=%h out_a0=%h required 0", i, out_a, out_b, out_a0);
            end
        end
    endtask

    task automatic test_write_read;
        write_reg(5'd5, 32'hDEADBEEF);
        read_regs(5'd5, 5'd5);
        checks++;
        if (out_a !== 32'hDEADBEEF || out_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read_r5: out_a=%h out_b=%h required deadbeef", out_a, out_b);
        end
        rs = 5'd0; rt = 5'd1;
        tick();
        tick();
        checks++;
        if (out_a !== 32'hDEADBEEF || out_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold_rd_en_low: out_a=%h out_b=%h required deadbeef", out_a, out_b);
        end
        write_reg(5'd30, 32'h0BADF00D);
        write_reg(5'd31, 32'hCAFEF00D);
        read_regs(5'd31, 5'd30);
        checks++;
        if (out_a !== 32'hCAFEF00D || out_b !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL back_to_back_r31_r30: out_a=%h out_b=%h required cafef00d/0badf00d", out_a, out_b);
        end
    endtask

    task automatic test_zero_reg;
        write_reg(5'd0, 32'h12345678);
        read_regs(5'd0, 5'd5);
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL zero_reg_1: out_a=%h out_b=%h required 0/deadbeef", out_a, out_b);
        end
        checks++;
        if (out_a0 !== 32'h12345678) begin
            errors++;
            $display("FAIL zero_reg_0: out_a0=%h required 12345678", out_a0);
        end
    endtask

    task automatic test_hazard;
        logic [31:0] exp_a;
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'h22222222;
`else
        exp_a = 32'h11111111;
`endif
        write_reg(5'd7, 32'h11111111);
        rd = 5'd7; wr_data = 32'h22222222; wr_en = 1'b1;
        rs = 5'd7; rt = 5'd5; rd_en = 1'b1;
        tick();
        idle();
        checks++;
        if (out_a !== exp_a || out_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hazard_same_edge: out_a=%h out_b=%h required %h/deadbeef", out_a, out_b, exp_a);
        end
        read_regs(5'd7, 5'd7);
        checks++;
        if (out_a !== 32'h22222222 || out_b !== 32'h22222222) begin
            errors++;
            $display("FAIL hazard_next_read: out_a=%h out_b=%h required 22222222", out_a, out_b);
        end
    endtask

    task automatic test_reset_mid;
        write_reg(5'd3, 32'hA5A5A5A5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: ready=%b out_a=%h out_b=%h required 0/0/0", ready, out_a, out_b);
        end
        rd = 5'd3; wr_data = 32'hA5A5A5A5; wr_en = 1'b1; rs = 5'd3; rt = 5'd3;
        wait_ready("reset_mid");
        read_regs(5'd3, 5'd5);
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_cleared: out_a=%h out_b=%h required 0", out_a, out_b);
        end
    endtask

    task automatic test_init_ignored;
        write_reg(5'd12, 32'h5A5A5A5A);
        read_regs(5'd12, 5'd12);
        rd = 5'd9; wr_data = 32'hFFFFFFFF; wr_en = 1'b1;
        rs = 5'd9; rt = 5'd9; rd_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || out_a !== 32'h0) begin
            errors++;
            $display("FAIL init_ignored_reset: ready=%b out_a=%h required 0/0", ready, out_a);
        end
        wait_ready("init_ignored");
        read_regs(5'd9, 5'd12);
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0) begin
            errors++;
            $display("FAIL init_ignored_r9: out_a=%h out_b=%h required 0", out_a, out_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_hazard();
        test_reset_mid();
        test_init_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
